// File: rtl/rv_fmul_unit.sv
// Multi-cycle IEEE-754 binary32 multiplier with valid/ready handshakes on both sides.
// Define FMUL_RNE_ROUND_EN for round-to-nearest-even; otherwise results truncate toward zero.
module rv_fmul_unit #(
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [1:0]  out_flags
);
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned SIG_W     = 24;
    localparam int unsigned PROD_W    = 48;
    localparam int unsigned EXP_W     = 10;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned MUL_STEPS = 24;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

    typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM, DONE} state_t;

    state_t                   state;
    logic [WORD_W-1:0]        a_q, b_q;
    logic                     sign_q;
    logic signed [EXP_W-1:0]  exp_q;
    logic [SIG_W-1:0]         ma_q;
    logic [PROD_W-1:0]        prod_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     spec_q;
    logic [WORD_W-1:0]        spec_res_q;
    logic [1:0]               spec_flags_q;

    // Operand classification and special-case result
    logic                     sign_c, a_nan_c, b_nan_c, a_inf_c, b_inf_c, a_zero_c, b_zero_c;
    logic signed [EXP_W-1:0]  exp_sum_c;
    logic                     spec_c;
    logic [WORD_W-1:0]        spec_res_c;
    logic [1:0]               spec_flags_c;

    always_comb begin
        sign_c       = a_q[31] ^ b_q[31];
        a_nan_c      = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan_c      = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
        a_inf_c      = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf_c      = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        a_zero_c     = (a_q[30:23] == 8'h00);
        b_zero_c     = (b_q[30:23] == 8'h00);
        exp_sum_c    = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]}) - 10'sd127;
        spec_c       = 1'b0;
        spec_res_c   = '0;
        spec_flags_c = 2'b00;
        if (a_nan_c || b_nan_c || (a_inf_c && b_zero_c) || (b_inf_c && a_zero_c)) begin
            spec_c       = 1'b1;
            spec_res_c   = CANON_NAN;
            spec_flags_c = 2'b10;
        end else if (a_inf_c || b_inf_c) begin
            spec_c     = 1'b1;
            spec_res_c = {sign_c, 8'hFF, 23'd0};
        end else if (a_zero_c || b_zero_c) begin
            spec_c     = 1'b1;
            spec_res_c = {sign_c, 31'd0};
        end
    end

    // One shift-add step: multiplier bit sits in prod_q[0], partial sum in the upper half
    logic [SIG_W:0] hi_sum_c;
    always_comb begin
        hi_sum_c = {1'b0, prod_q[47:24]} + (prod_q[0] ? {1'b0, ma_q} : 25'd0);
    end

    // Normalise, round, saturate
    logic [SIG_W-1:0]        mant_c;
    logic signed [EXP_W-1:0] exp_n_c, exp_r_c;
    logic                    inc_c;
    logic [SIG_W:0]          rnd_c;
    logic [22:0]             frac_c;
    logic [WORD_W-1:0]       norm_res_c;
    logic [1:0]              norm_flags_c;

    always_comb begin
        if (prod_q[47]) begin
            mant_c  = prod_q[47:24];
            exp_n_c = exp_q + 10'sd1;
        end else begin
            mant_c  = prod_q[46:23];
            exp_n_c = exp_q;
        end
        inc_c = 1'b0;
`ifdef FMUL_RNE_ROUND_EN
        if (prod_q[47])
            inc_c = prod_q[23] & ((|prod_q[22:0]) | prod_q[24]);
        else
            inc_c = prod_q[22] & ((|prod_q[21:0]) | prod_q[23]);
`endif
        rnd_c        = {1'b0, mant_c} + 25'(inc_c);
        frac_c       = rnd_c[24] ? rnd_c[23:1] : rnd_c[22:0];
        exp_r_c      = exp_n_c + $signed({9'd0, rnd_c[24]});
        norm_flags_c = 2'b00;
        if (exp_r_c >= 10'sd255) begin
            norm_res_c   = {sign_q, 8'hFF, 23'd0};
            norm_flags_c = 2'b01;
        end else if (exp_r_c <= 10'sd0) begin
            norm_res_c = {sign_q, 31'd0};
        end else begin
            norm_res_c = {sign_q, exp_r_c[7:0], frac_c};
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_flags    <= 2'b00;
            a_q          <= '0;
            b_q          <= '0;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            ma_q         <= '0;
            prod_q       <= '0;
            cnt_q        <= '0;
            spec_q       <= 1'b0;
            spec_res_q   <= '0;
            spec_flags_q <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        in_ready <= 1'b0;
                        state    <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_q       <= sign_c;
                    exp_q        <= exp_sum_c;
                    ma_q         <= {1'b1, a_q[22:0]};
                    prod_q       <= {24'd0, 1'b1, b_q[22:0]};
                    cnt_q        <= '0;
                    spec_q       <= spec_c;
                    spec_res_q   <= spec_res_c;
                    spec_flags_q <= spec_flags_c;
                    state        <= spec_c ? NORM : MUL;
                end
                MUL: begin
                    prod_q <= {hi_sum_c, prod_q[23:1]};
                    if (cnt_q == LAST_STEP) begin
                        cnt_q <= '0;
                        state <= NORM;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                NORM: begin
                    out_result <= spec_q ? spec_res_q : norm_res_c;
                    out_flags  <= spec_q ? spec_flags_q : norm_flags_c;
                    out_valid  <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_fmul_unit.sv
// Directed bench for rv_fmul_unit: scoreboard of expected result/flags/latency per accepted op.
module tb_rv_fmul_unit;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [1:0]  out_flags;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  flags;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    rv_fmul_unit #(.CANON_NAN(32'h7FC00000)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand pair, wait for acceptance and queue what should come back
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [1:0] flags, input int lat);
        exp_t e;
        int   n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("in_ready_before_issue", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
        e.res    = res;
        e.flags  = flags;
        e.lat    = lat;
        sb.push_back(e);
    endtask

    // Count edges until out_valid, then compare against the oldest queued expectation
    task automatic wait_result(input string tag);
        exp_t e;
        int   lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
            chk({tag, "_result"}, out_result, e.res);
            chk({tag, "_flags"}, 32'(out_flags), 32'(e.flags));
        end
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [1:0] flags, input int lat);
        issue(a, b, res, flags, lat);
        wait_result(tag);
        retire(tag);
    endtask

    initial begin
        logic [31:0] rne_exp;
        int          seen;

        // Reset state
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Normal products, rounding, saturation and bypass cases
        run("two_times_three", 32'h40000000, 32'h40400000, 32'h40C00000, 2'b00, 26);
`ifdef FMUL_RNE_ROUND_EN
        rne_exp = 32'h3FC00002;
`else
        rne_exp = 32'h3FC00001;
`endif
        run("round_tie", 32'h3F800001, 32'h3FC00000, rne_exp, 2'b00, 26);
        run("inf_times_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 2'b10, 2);
        run("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000, 2'b01, 26);
        run("neg_two", 32'hC0000000, 32'h3F800000, 32'hC0000000, 2'b00, 26);
        run("nan_operand", 32'h7FC12345, 32'h3F800000, 32'h7FC00000, 2'b10, 2);
        run("neg_inf", 32'hFF800000, 32'h40000000, 32'hFF800000, 2'b00, 2);
        run("signed_zero", 32'h00000000, 32'hC0400000, 32'h80000000, 2'b00, 2);
        run("subnormal_flush", 32'h00000001, 32'h40000000, 32'h00000000, 2'b00, 2);
        run("underflow", 32'h00800000, 32'h80800000, 32'h80000000, 2'b00, 26);

        // Back-pressure: result held, busy unit ignores a new offer
        issue(32'h40400000, 32'h40400000, 32'h41100000, 2'b00, 26);
        wait_result("stall");
        in_valid = 1'b1;
        in_a     = 32'h3F800000;
        in_b     = 32'h3F800000;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_valid_held", 32'(out_valid), 32'd1);
            chk("stall_result_held", out_result, 32'h41100000);
            chk("stall_in_ready_low", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        retire("stall");
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (out_valid === 1'b1) seen++;
        end
        chk("stall_no_second_result", 32'(seen), 32'd0);

        // Reset in the middle of MUL discards the operation
        issue(32'h40000000, 32'h40000000, 32'h40800000, 2'b00, 26);
        for (int i = 0; i < 13; i++) step();
        #2;
        rstn = 1'b0;
        #1;
        sb.delete();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_result", out_result, 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid === 1'b1) seen++;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);
        run("after_reset", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 2'b00, 26);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
